// File: rtl/video_pkg.sv
// video_pkg: shared bank-controller state type, default frame geometry and bank index width
package video_pkg;
  typedef enum logic [0:0] {FILL = 1'b0, FULL_WAIT = 1'b1} bank_state_e;
  localparam int DEF_WIDTH = 200;
  localparam int DEF_HEIGHT = 150;
  localparam int DEF_NUM_BANKS = 16;
  localparam int BANK_W = 4;
endpackage

// File: rtl/frame_raster_counter.sv
// frame_raster_counter: x/y raster scan counter with a pulse on the final pixel of a frame
module frame_raster_counter import video_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          wrap
);
  logic x_last, y_last;
  assign x_last = x == XW'(WIDTH - 1);
  assign y_last = y == YW'(HEIGHT - 1);
  assign wrap = en && x_last && y_last;
  always_ff @(posedge clk)
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      x <= x_last ? '0 : x + 1'b1;
      if (x_last) y <= y_last ? '0 : y + 1'b1;
    end
endmodule

// File: rtl/video_bank_ctrl.sv
// video_bank_ctrl: frame-bank fill/display controller; BANK_UNDERRUN_STATS_EN adds a saturating underrun_cnt output
module video_bank_ctrl import video_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int FRAME_DIV = 2,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int RW = $clog2(NUM_BANKS) + 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid,
  input  logic              pix_data,
  output logic              pix_ready,
  input  logic              frame_tick,
  output logic [XW-1:0]     wr_x,
  output logic [YW-1:0]     wr_y,
  output logic              wr_data,
  output logic              wr_en,
  output logic [BANK_W-1:0] wr_bank,
  output logic [BANK_W-1:0] disp_bank,
  output logic [RW-1:0]     banks_ready
`ifdef BANK_UNDERRUN_STATS_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);
  localparam int DW = FRAME_DIV > 1 ? $clog2(FRAME_DIV) : 1;
  localparam logic [BANK_W-1:0] BANK_MASK = BANK_W'(NUM_BANKS - 1);
  localparam logic [RW-1:0] FULL_LVL = RW'(NUM_BANKS - 1);
  bank_state_e state;
  logic [BANK_W-1:0] fill_bank;
  logic [DW-1:0] div;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic acc, done, div_wrap, adv;
  assign pix_ready = rst_n && state == FILL;
  assign acc = pix_valid && pix_ready;
  assign div_wrap = frame_tick && div == DW'(FRAME_DIV - 1);
  assign adv = div_wrap && banks_ready != '0;
  frame_raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_scan (
    .clk(clk),
    .rst_n(rst_n),
    .en(acc),
    .x(cx),
    .y(cy),
    .wrap(done)
  );
  // wr_bank lags fill_bank by one cycle so it always names the bank of the write on the bus
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= FILL;
      fill_bank <= BANK_W'(1);
      wr_bank <= BANK_W'(1);
      disp_bank <= '0;
      banks_ready <= '0;
      div <= '0;
      wr_en <= 1'b0;
      wr_data <= 1'b0;
      wr_x <= '0;
      wr_y <= '0;
    end else begin
      wr_en <= acc;
      wr_bank <= fill_bank;
      if (acc) begin
        wr_x <= cx;
        wr_y <= cy;
        wr_data <= pix_data;
      end
      if (done) fill_bank <= (fill_bank + 1'b1) & BANK_MASK;
      if (adv) disp_bank <= (disp_bank + 1'b1) & BANK_MASK;
      if (frame_tick) div <= div_wrap ? '0 : div + 1'b1;
      banks_ready <= done && !adv ? banks_ready + 1'b1 : adv && !done ? banks_ready - 1'b1 : banks_ready;
      state <= adv ? FILL : done && banks_ready + 1'b1 == FULL_LVL ? FULL_WAIT : state;
    end
`ifdef BANK_UNDERRUN_STATS_EN
  always_ff @(posedge clk)
    if (!rst_n) underrun_cnt <= '0;
    else if (div_wrap && banks_ready == '0 && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_video_bank_ctrl.sv
// tb_video_bank_ctrl: randomized and directed checks of video_bank_ctrl against a pixel-count model
module tb_video_bank_ctrl;
  localparam int W = 10;
  localparam int H = 6;
  localparam int NB = 16;
  localparam int FD = 2;
  logic clk, rst_n, pix_valid, pix_data, pix_ready, frame_tick, wr_data, wr_en;
  logic [3:0] wr_x;
  logic [2:0] wr_y;
  logic [3:0] wr_bank, disp_bank;
  logic [4:0] banks_ready;
`ifdef BANK_UNDERRUN_STATS_EN
  logic [15:0] underrun_cnt;
`endif
  int total = 0;
  int bad = 0;
  bit on = 0;
  int m_idx, m_fill, m_disp, m_ready, m_ticks, m_und;
  int e_en, e_x, e_y, e_data, e_bank;
  logic acc_m, done_m, wrap_m, adv_m;

  video_bank_ctrl #(.WIDTH(W), .HEIGHT(H), .NUM_BANKS(NB), .FRAME_DIV(FD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .pix_ready(pix_ready),
    .frame_tick(frame_tick),
    .wr_x(wr_x),
    .wr_y(wr_y),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .wr_bank(wr_bank),
    .disp_bank(disp_bank),
    .banks_ready(banks_ready)
`ifdef BANK_UNDERRUN_STATS_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // The controller is full exactly when NB-1 finished banks are waiting.
  assign acc_m = pix_valid && m_ready < NB - 1;
  assign done_m = acc_m && m_idx == W * H - 1;
  assign wrap_m = frame_tick && m_ticks == FD - 1;
  assign adv_m = wrap_m && m_ready > 0;

  always @(posedge clk)
    if (!rst_n) begin
      m_idx <= 0;
      m_fill <= 1;
      m_disp <= 0;
      m_ready <= 0;
      m_ticks <= 0;
      m_und <= 0;
      e_en <= 0;
      e_x <= 0;
      e_y <= 0;
      e_data <= 0;
      e_bank <= 1;
    end else begin
      e_en <= int'(acc_m);
      e_bank <= m_fill;
      if (acc_m) begin
        e_x <= m_idx % W;
        e_y <= m_idx / W;
        e_data <= int'(pix_data);
        m_idx <= done_m ? 0 : m_idx + 1;
      end
      if (done_m) m_fill <= (m_fill + 1) % NB;
      if (adv_m) m_disp <= (m_disp + 1) % NB;
      m_ready <= m_ready + int'(done_m) - int'(adv_m);
      if (frame_tick) m_ticks <= wrap_m ? 0 : m_ticks + 1;
      if (wrap_m && m_ready == 0 && m_und < 65535) m_und <= m_und + 1;
    end

  always @(negedge clk)
    if (on) begin
      chk("pix_ready", pix_ready, rst_n && m_ready < NB - 1);
      chk("wr_en", wr_en, e_en);
      chk("wr_bank", wr_bank, e_bank);
      chk("disp_bank", disp_bank, m_disp);
      chk("banks_ready", banks_ready, m_ready);
      if (e_en != 0) begin
        chk("wr_x", wr_x, e_x);
        chk("wr_y", wr_y, e_y);
        chk("wr_data", wr_data, e_data);
        chk("bank_clash", wr_bank == disp_bank, 0);
      end
`ifdef BANK_UNDERRUN_STATS_EN
      chk("underrun_cnt", underrun_cnt, m_und);
`endif
    end

  task automatic do_reset();
    rst_n = 0;
    pix_valid = 0;
    frame_tick = 0;
    step();
    rst_n = 1;
  endtask

  task automatic stream(input int n);
    pix_valid = 1;
    for (int i = 0; i < n; i++) begin
      pix_data = 1'($urandom);
      step();
    end
  endtask

  initial begin
    rst_n = 0;
    pix_valid = 0;
    pix_data = 0;
    frame_tick = 0;
    repeat (3) step();
    on = 1;
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_wr_bank", wr_bank, 1);
    chk("rst_disp_bank", disp_bank, 0);
    chk("rst_banks_ready", banks_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    rst_n = 1;
    #1;
    chk("ready_after_rst", pix_ready, 1);
    stream(W * H);
    chk("last_wr_en", wr_en, 1);
    chk("last_wr_x", wr_x, W - 1);
    chk("last_wr_y", wr_y, H - 1);
    chk("one_bank_ready", banks_ready, 1);
    pix_valid = 0;
    step();
    chk("wr_bank_adv", wr_bank, 2);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      frame_tick = 1;
      step();
      frame_tick = 0;
      step();
    end
    chk("underrun_disp", disp_bank, 0);
`ifdef BANK_UNDERRUN_STATS_EN
    chk("underrun_lit", underrun_cnt, 5);
`endif
    do_reset();
    stream(15 * W * H + 20);
    chk("full_ready", pix_ready, 0);
    chk("full_banks", banks_ready, 15);
    chk("full_wr_en", wr_en, 0);
    frame_tick = 1;
    step();
    step();
    frame_tick = 0;
    chk("drain_disp", disp_bank, 1);
    chk("drain_banks", banks_ready, 14);
    chk("drain_ready", pix_ready, 1);
    pix_valid = 0;
    do_reset();
    stream(W * H);
    pix_valid = 0;
    frame_tick = 1;
    step();
    frame_tick = 0;
    stream(W * H - 1);
    frame_tick = 1;
    stream(1);
    frame_tick = 0;
    pix_valid = 0;
    chk("coinc_banks", banks_ready, 1);
    chk("coinc_disp", disp_bank, 1);
    step();
    chk("coinc_wr_bank", wr_bank, 3);
    do_reset();
    stream(45);
    rst_n = 0;
    step();
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_x", wr_x, 0);
    chk("mid_rst_y", wr_y, 0);
    chk("mid_rst_bank", wr_bank, 1);
    chk("mid_rst_ready", banks_ready, 0);
    rst_n = 1;
    step();
    chk("restart_en", wr_en, 1);
    chk("restart_x", wr_x, 0);
    chk("restart_y", wr_y, 0);
    chk("restart_bank", wr_bank, 1);
    for (int ph = 0; ph < 2; ph++)
      for (int i = 0; i < 2000; i++) begin
        pix_valid = $urandom_range(0, 9) < 7;
        pix_data = 1'($urandom);
        frame_tick = $urandom_range(0, ph == 0 ? 99 : 14) == 0;
        rst_n = $urandom_range(0, 599) != 0;
        step();
      end
    rst_n = 1;
    pix_valid = 0;
    frame_tick = 0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/video_bank_ctrl.md
VIDEO_BANK_CTRL -- requirements
Module: video_bank_ctrl

Interface
REQ-001 Parameter WIDTH, default 200, frame width in pixels.
REQ-002 Parameter HEIGHT, default 150, frame height in pixels.
REQ-003 Parameter NUM_BANKS, default 16, number of frame banks in video RAM (power of 2, ≤16).
REQ-004 Parameter FRAME_DIV, default 2, display frame_ticks per decoded frame (≥1).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 pix_valid  in  1  incoming pixel stream valid.
REQ-008 pix_data  in  1  incoming pixel (1=white).
REQ-009 pix_ready  out  1  controller accepts pixel this cycle.
REQ-010 frame_tick  in  1  one-cycle pulse at display vsync.
REQ-011 wr_x  out  $clog2(WIDTH)  write column.
REQ-012 wr_y  out  $clog2(HEIGHT)  write row.
REQ-013 wr_data  out  1  pixel written.
REQ-014 wr_en  out  1  video RAM write enable.
REQ-015 wr_bank  out  4  bank being filled.
REQ-016 disp_bank  out  4  bank being displayed (drives bank_counter).
REQ-017 banks_ready  out  $clog2(NUM_BANKS)+1  complete, undisplayed banks.

Function
REQ-018 Pixel accepted iff pix_valid && pix_ready; accepted pixel SHALL appear as wr_en=1, wr_data/wr_x/wr_y/wr_bank on the next cycle (1-cycle latency, registered).
REQ-019 Write scan raster order: wr_x increments 0..WIDTH-1, wraps to 0 with wr_y+1; after (WIDTH-1,HEIGHT-1) both wrap to 0 and the bank is complete.
REQ-020 FSM states FILL, FULL_WAIT: FILL→FULL_WAIT when a bank completes and banks_ready (post-increment) = NUM_BANKS-1; FULL_WAIT→FILL when display frees a bank.
REQ-021 pix_ready=1 only in FILL; in FULL_WAIT pix_ready=0 and wr_en=0.
REQ-022 On bank completion, wr_bank SHALL advance modulo NUM_BANKS and banks_ready SHALL increment.
REQ-023 Frame divider counts frame_tick 0..FRAME_DIV-1; at the wrapping tick, if banks_ready>0, disp_bank advances modulo NUM_BANKS and banks_ready decrements; else disp_bank holds (underrun, frame repeated).
REQ-024 Bank completion and display advance in same cycle: banks_ready unchanged, both pointers advance, FSM stays/returns FILL.
REQ-025 wr_bank SHALL never equal disp_bank while wr_en=1 except at startup before first completion.
REQ-026 banks_ready SHALL never exceed NUM_BANKS-1 nor underflow.

Reset
REQ-027 With rst_n=0 at a clock edge: FSM=FILL, wr_x=wr_y=0, wr_bank=1, disp_bank=0, banks_ready=0, frame divider=0, wr_en=0, wr_data=0, pix_ready=0 during reset, 1 first cycle after.
REQ-028 Reset mid-frame discards the partial bank; no write issued in the reset cycle.

Configuration
REQ-029 Macro BANK_UNDERRUN_STATS_EN: when defined, adds output underrun_cnt (16 bits, saturating) incremented on each REQ-023 underrun, cleared by reset; when undefined, port and counter absent, behaviour otherwise identical.

Structure
REQ-030 Shared package video_pkg SHALL hold the FSM state enum, the default WIDTH/HEIGHT/NUM_BANKS constants and the bank index width (4).
REQ-031 One sub-module, frame_raster_counter (x/y raster counter with wrap pulse), SHALL be instantiated for the write scan.

Verification
REQ-032 Reset then stream 30000 pixels with pix_valid=1 -> wr_bank goes 1→2, banks_ready=1, last write at (199,149).
REQ-033 No pixels, 10 frame_ticks, FRAME_DIV=2 -> disp_bank stays 0, (with macro) underrun_cnt=5.
REQ-034 Continuous input, no frame_tick -> after 15 banks pix_ready=0, banks_ready=15, wr_en stays 0.
REQ-035 From REQ-034 state, one divider wrap -> disp_bank+1, banks_ready=14, pix_ready=1 next cycle.
REQ-036 Bank completion coincident with divider wrap -> banks_ready unchanged, both pointers +1.
REQ-037 Assert rst_n=0 at pixel 12345 -> all outputs at REQ-027 values, next stream restarts at (0,0) bank 1.
